vliw_fetch_unit: RTL and testbench
==================================

# vliw_fetch_unit

Instruction-fetch stage of the VLIW pipeline. It holds the program counter, issues bundle requests to instruction memory over a req/ack handshake and buffers returned bundles in a 1-entry output slot plus a 1-entry skid. It drives the write-enable and flush inputs of the IF/ID pipeline register bank directly downstream, and it absorbs stalls from the hazard unit and redirects from the branch unit.

## Interface
- ISSUE, 2, operations per bundle; BW = 32*ISSUE, PC step = 4*ISSUE
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- clk  input  1  clock; all state updates on rising edge (IF/ID captures on the following falling edge)
- reset  input  1  reset, asynchronous, active-low (0 = reset)
- stall  input  1  hazard unit holds IF/ID; presented bundle not consumed
- redirect  input  1  branch/jump taken, single-cycle pulse
- redirect_pc  input  32  target PC, valid with redirect
- imem_req  output  1  memory request
- imem_addr  output  32  bundle address, BW/8-aligned
- imem_ack  input  1  response valid; 1 cycle per request, latency ≥1 cycle after req first seen
- imem_rdata  input  BW  bundle data, valid with imem_ack
- if_bundle  output  BW  bundle to IF/ID
- if_pc  output  32  PC of if_bundle
- if_valid  output  1  output slot holds a bundle
- if_write  output  1  IF/ID write enable = if_valid & ~stall & ~redirect
- if_flush  output  1  IF/ID flush, one-cycle pulse after redirect

## Operation
- State: pc, fsm {IDLE, REQ, KILL}, slot (valid, bundle, pc), skid (valid, bundle, pc).
- Reset values: pc=RESET_PC, fsm=IDLE, slot/skid invalid. imem_req=0, imem_addr=RESET_PC, if_bundle=0, if_pc=0, if_valid=0, if_write=0, if_flush=0.
- IDLE: go to REQ when skid is empty and no redirect is present. The first edge after reset release always goes to REQ.
- REQ: imem_req=1, imem_addr=pc. Both are held stable until imem_ack; a request is never withdrawn.
- On ack in REQ with no redirect:
  - pc += 4*ISSUE.
  - Data goes to the slot if the slot is empty or draining (if_write=1); otherwise it goes to the skid.
  - Next state is REQ if the skid is empty after this edge, else IDLE.
- Slot drain: when if_write=1, the slot reloads from the skid if the skid is valid, else from the ack data, else it goes invalid.
- redirect (priority over stall and ack):
  - slot and skid are invalidated and pc=redirect_pc.
  - if_flush=1 for the next cycle.
  - If REQ is outstanding without ack this cycle, go to KILL; otherwise go to REQ.
- KILL: imem_req stays 1 with the old address. On ack the data is discarded and the FSM goes to REQ at the new pc. A further redirect in KILL only updates pc.
- PC arithmetic: 32-bit modulo wrap, so 32'hFFFF_FFF8 + 8 = 0. The low log2(4*ISSUE) bits of redirect_pc are ignored (forced 0).

## Timing
- Ack sampled at edge k: if_valid=1 and if_bundle valid from edge k. Next imem_req with pc+8 is asserted from edge k if the skid is empty.
- Zero-wait memory (ack in the cycle after req): one bundle per cycle sustained while stall=0.
- Redirect at edge k: if_flush=1 for cycle k..k+1. imem_addr=redirect_pc from edge k if no request is outstanding, else from the edge after the killed ack.
- Stall with slot and skid full: no new request. Stored bundles are never lost or reordered.
- stall and redirect together: redirect wins and if_write=0.
- Reset asserted mid-request: all state clears immediately. A stale ack arriving after reset release while in IDLE is ignored.

## Structure
- Shared pipeline package holds FETCH_IDLE/FETCH_REQ/FETCH_KILL encodings, BW and the PC-step constant.
- One sub-module, fetch_skid_buf: slot+skid 2-entry buffer with push/pop/clear, reporting full and valid.

## Test plan
- Reset with RESET_PC=32'h100, zero-wait memory, stall=0: addresses 100,108,110 on consecutive cycles; if_pc follows one cycle later; if_write=1 continuously.
- stall=1 for 4 cycles during streaming: at most 2 bundles buffered and imem_req drops. On release, bundles come out in order 108,110 with none lost or duplicated.
- redirect to 32'h400 while a 3-cycle-latency request to 118 is outstanding: KILL, the ack for 118 is discarded, if_flush is pulsed once and the next imem_addr is 400.
- redirect and stall in the same cycle with the slot full: slot cleared, if_write=0, if_flush=1 next cycle.
- PC wrap: redirect to FFFF_FFF8, then 2 acks: addresses FFFF_FFF8 then 0000_0000.
- Reset asserted mid-request with the skid full: all outputs return to their reset values asynchronously. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/vliw_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM encodings, bundle width and PC step.
package vliw_fetch_unit_pkg;

    localparam int unsigned FETCH_ISSUE   = 2;
    localparam int unsigned FETCH_BW      = 32 * FETCH_ISSUE;
    localparam logic [31:0] FETCH_PC_STEP = 32'(4 * FETCH_ISSUE);

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_KILL = 2'd2
    } fetch_state_e;

    // Clear the byte-offset bits below the bundle alignment.
    function automatic logic [31:0] align_pc(input logic [31:0] pc, input logic [31:0] step);
        return pc & ~(step - 32'd1);
    endfunction

endpackage

// File: rtl/vliw_fetch_unit_skid_buf.sv
// Two-entry bundle buffer: an output slot backed by a one-entry skid.
module fetch_skid_buf
    import vliw_fetch_unit_pkg::*;
#(
    parameter int unsigned BW = FETCH_BW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [BW-1:0] push_data_i,
    input  logic [31:0]   push_pc_i,
    input  logic          pop_i,
    output logic          slot_valid_o,
    output logic [BW-1:0] slot_data_o,
    output logic [31:0]   slot_pc_o,
    output logic          full_o
);

    logic          slot_v_q, slot_v_d;
    logic [BW-1:0] slot_data_q, slot_data_d;
    logic [31:0]   slot_pc_q, slot_pc_d;
    logic          skid_v_q, skid_v_d;
    logic [BW-1:0] skid_data_q, skid_data_d;
    logic [31:0]   skid_pc_q, skid_pc_d;

    // Slot refills from the skid first so bundle order is preserved.
    always_comb begin
        slot_v_d    = slot_v_q;
        slot_data_d = slot_data_q;
        slot_pc_d   = slot_pc_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        if (clear_i) begin
            slot_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (pop_i || !slot_v_q) begin
            if (skid_v_q) begin
                slot_v_d    = 1'b1;
                slot_data_d = skid_data_q;
                slot_pc_d   = skid_pc_q;
                skid_v_d    = push_i;
                skid_data_d = push_data_i;
                skid_pc_d   = push_pc_i;
            end else if (push_i) begin
                slot_v_d    = 1'b1;
                slot_data_d = push_data_i;
                slot_pc_d   = push_pc_i;
            end else begin
                slot_v_d = 1'b0;
            end
        end else if (push_i) begin
            skid_v_d    = 1'b1;
            skid_data_d = push_data_i;
            skid_pc_d   = push_pc_i;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_v_q    <= 1'b0;
            slot_data_q <= '0;
            slot_pc_q   <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            slot_v_q    <= slot_v_d;
            slot_data_q <= slot_data_d;
            slot_pc_q   <= slot_pc_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign slot_valid_o = slot_v_q;
    assign slot_data_o  = slot_data_q;
    assign slot_pc_o    = slot_pc_q;
    assign full_o       = skid_v_q;

endmodule

// File: rtl/vliw_fetch_unit.sv
// VLIW instruction fetch: PC, imem req/ack handshake, redirect kill, IF/ID control.
module vliw_fetch_unit
    import vliw_fetch_unit_pkg::*;
#(
    parameter int unsigned ISSUE    = FETCH_ISSUE,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    output logic                imem_req_o,
    output logic [31:0]         imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [32*ISSUE-1:0] imem_rdata_i,
    output logic [32*ISSUE-1:0] if_bundle_o,
    output logic [31:0]         if_pc_o,
    output logic                if_valid_o,
    output logic                if_write_o,
    output logic                if_flush_o
);

    localparam int unsigned BW      = 32 * ISSUE;
    localparam logic [31:0] PC_STEP = 32'(4 * ISSUE);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  addr_q;
    logic         req_q;
    logic         flush_q;

    logic        slot_valid;
    logic        skid_full;
    logic        push;
    logic        skid_after;
    logic [31:0] target_pc;
    logic [31:0] next_pc;

    assign target_pc  = align_pc(redirect_pc_i, PC_STEP);
    assign next_pc    = pc_q + PC_STEP;
    assign if_write_o = slot_valid & ~stall_i & ~redirect_i;
    assign push       = (state_q == FETCH_REQ) & imem_ack_i & ~redirect_i;
    // Skid holds a bundle after this edge if the slot stays occupied when data lands.
    assign skid_after = slot_valid & (~if_write_o | skid_full);

    fetch_skid_buf #(
        .BW (BW)
    ) u_buf (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (redirect_i),
        .push_i       (push),
        .push_data_i  (imem_rdata_i),
        .push_pc_i    (addr_q),
        .pop_i        (if_write_o),
        .slot_valid_o (slot_valid),
        .slot_data_o  (if_bundle_o),
        .slot_pc_o    (if_pc_o),
        .full_o       (skid_full)
    );

    // Fetch FSM with registered request, address and flush outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= redirect_i;
            unique case (state_q)
                FETCH_IDLE: begin
                    if (redirect_i) begin
                        pc_q    <= target_pc;
                        addr_q  <= target_pc;
                        req_q   <= 1'b1;
                        state_q <= FETCH_REQ;
                    end else if (!skid_full) begin
                        addr_q  <= pc_q;
                        req_q   <= 1'b1;
                        state_q <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (redirect_i) begin
                        pc_q <= target_pc;
                        if (imem_ack_i) begin
                            addr_q <= target_pc;
                        end else begin
                            // Request cannot be withdrawn: hold old address until its ack.
                            state_q <= FETCH_KILL;
                        end
                    end else if (imem_ack_i) begin
                        pc_q <= next_pc;
                        if (skid_after) begin
                            req_q   <= 1'b0;
                            state_q <= FETCH_IDLE;
                        end else begin
                            addr_q <= next_pc;
                        end
                    end
                end
                FETCH_KILL: begin
                    if (redirect_i) begin
                        pc_q <= target_pc;
                    end
                    if (imem_ack_i) begin
                        addr_q  <= redirect_i ? target_pc : pc_q;
                        state_q <= FETCH_REQ;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= FETCH_IDLE;
                end
            endcase
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign if_valid_o  = slot_valid;
    assign if_flush_o  = flush_q;

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Directed bench for vliw_fetch_unit with a variable-latency instruction memory model.
module tb_vliw_fetch_unit;

    localparam int unsigned BW = 64;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          imem_req;
    logic [31:0]  imem_addr;
    logic          imem_ack;
    logic [BW-1:0] imem_rdata;
    logic [BW-1:0] if_bundle;
    logic [31:0]   if_pc;
    logic          if_valid;
    logic          if_write;
    logic          if_flush;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned lat     = 1;
    int unsigned cnt     = 0;
    bit          busy    = 1'b0;
    logic [31:0] maddr;

    vliw_fetch_unit #(
        .ISSUE    (2),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .if_bundle_o   (if_bundle),
        .if_pc_o       (if_pc),
        .if_valid_o    (if_valid),
        .if_write_o    (if_write),
        .if_flush_o    (if_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] bundle_of(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory: sees a new request #1 after an edge, acks 'lat' cycles later for one cycle.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_ack) imem_ack = 1'b0;
            if (!busy && imem_req) begin
                busy  = 1'b1;
                cnt   = lat;
                maddr = imem_addr;
            end
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = bundle_of(maddr);
                    busy       = 1'b0;
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_req",    64'(imem_req),  64'd0);
        check_eq("rst_addr",   64'(imem_addr), 64'h100);
        check_eq("rst_valid",  64'(if_valid),  64'd0);
        check_eq("rst_write",  64'(if_write),  64'd0);
        check_eq("rst_flush",  64'(if_flush),  64'd0);
        check_eq("rst_bundle", if_bundle,      64'd0);
        check_eq("rst_pc",     64'(if_pc),     64'd0);
        rst_n = 1'b1;

        // Zero-wait streaming
        step(); // E1
        check_eq("e1_req",   64'(imem_req),  64'd1);
        check_eq("e1_addr",  64'(imem_addr), 64'h100);
        check_eq("e1_valid", 64'(if_valid),  64'd0);
        step(); // E2
        check_eq("e2_addr",   64'(imem_addr), 64'h108);
        check_eq("e2_pc",     64'(if_pc),     64'h100);
        check_eq("e2_bundle", if_bundle,      bundle_of(32'h100));
        check_eq("e2_write",  64'(if_write),  64'd1);
        step(); // E3
        check_eq("e3_addr",  64'(imem_addr), 64'h110);
        check_eq("e3_pc",    64'(if_pc),     64'h108);
        check_eq("e3_write", 64'(if_write),  64'd1);

        // Stall four cycles: slot 108, skid 110, request stops
        stall = 1'b1;
        step(); // E4
        check_eq("st_req",   64'(imem_req), 64'd0);
        check_eq("st_valid", 64'(if_valid), 64'd1);
        check_eq("st_pc",    64'(if_pc),    64'h108);
        check_eq("st_write", 64'(if_write), 64'd0);
        repeat (3) step(); // E7
        check_eq("st_req_hold", 64'(imem_req), 64'd0);
        check_eq("st_pc_hold",  64'(if_pc),    64'h108);
        stall = 1'b0;
        #1;
        check_eq("rel_write0", 64'(if_write), 64'd1);
        step(); // E8
        check_eq("rel_pc1",    64'(if_pc),    64'h110);
        check_eq("rel_write1", 64'(if_write), 64'd1);
        check_eq("rel_req1",   64'(imem_req), 64'd0);
        lat = 3;
        step(); // E9
        check_eq("rel_valid2", 64'(if_valid),  64'd0);
        check_eq("rel_req2",   64'(imem_req),  64'd1);
        check_eq("rel_addr2",  64'(imem_addr), 64'h118);

        // Redirect while the 3-cycle request to 118 is outstanding
        step(); // E10
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        step(); // E11
        check_eq("kill_flush", 64'(if_flush),  64'd1);
        check_eq("kill_addr",  64'(imem_addr), 64'h118);
        check_eq("kill_req",   64'(imem_req),  64'd1);
        redirect = 1'b0;
        lat      = 1;
        step(); // E12
        check_eq("kill_flush_off", 64'(if_flush),  64'd0);
        check_eq("kill_new_addr",  64'(imem_addr), 64'h400);
        check_eq("kill_discard",   64'(if_valid),  64'd0);
        step(); // E13
        check_eq("tgt_valid", 64'(if_valid),  64'd1);
        check_eq("tgt_pc",    64'(if_pc),     64'h400);
        check_eq("tgt_addr",  64'(imem_addr), 64'h408);

        // Redirect and stall together with the slot full; low target bits ignored
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        #1;
        check_eq("rs_write", 64'(if_write), 64'd0);
        step(); // E14
        check_eq("rs_valid", 64'(if_valid),  64'd0);
        check_eq("rs_flush", 64'(if_flush),  64'd1);
        check_eq("rs_addr",  64'(imem_addr), 64'hFFFF_FFF8);
        check_eq("rs_req",   64'(imem_req),  64'd1);
        stall    = 1'b0;
        redirect = 1'b0;

        // PC wrap
        step(); // E15
        check_eq("wrap_pc0",     64'(if_pc),     64'hFFFF_FFF8);
        check_eq("wrap_bundle0", if_bundle,      bundle_of(32'hFFFF_FFF8));
        check_eq("wrap_addr0",   64'(imem_addr), 64'h0);
        check_eq("wrap_flush",   64'(if_flush),  64'd0);
        step(); // E16
        check_eq("wrap_pc1",   64'(if_pc),     64'h0);
        check_eq("wrap_addr1", 64'(imem_addr), 64'h8);

        // Fill skid, drain, then reset in the middle of a 3-cycle request
        stall = 1'b1;
        step(); // E17
        check_eq("fill_req", 64'(imem_req), 64'd0);
        check_eq("fill_pc",  64'(if_pc),    64'h0);
        stall = 1'b0;
        lat   = 3;
        step(); // E18
        check_eq("drain_pc",  64'(if_pc),    64'h8);
        check_eq("drain_req", 64'(imem_req), 64'd0);
        step(); // E19
        check_eq("mid_req",   64'(imem_req),  64'd1);
        check_eq("mid_addr",  64'(imem_addr), 64'h10);
        check_eq("mid_valid", 64'(if_valid),  64'd0);
        step(); // E20
        rst_n = 1'b0;
        #1;
        check_eq("arst_req",    64'(imem_req),  64'd0);
        check_eq("arst_addr",   64'(imem_addr), 64'h100);
        check_eq("arst_valid",  64'(if_valid),  64'd0);
        check_eq("arst_flush",  64'(if_flush),  64'd0);
        check_eq("arst_bundle", if_bundle,      64'd0);
        check_eq("arst_pc",     64'(if_pc),     64'd0);
        step(); // E21: stale ack raised by memory after this edge
        check_eq("arst_hold_req", 64'(imem_req), 64'd0);
        rst_n = 1'b1;
        lat   = 1;
        step(); // E22
        check_eq("restart_req",   64'(imem_req),  64'd1);
        check_eq("restart_addr",  64'(imem_addr), 64'h100);
        check_eq("stale_ignored", 64'(if_valid),  64'd0);
        step(); // E23
        check_eq("restart_pc",     64'(if_pc),     64'h100);
        check_eq("restart_bundle", if_bundle,      bundle_of(32'h100));
        check_eq("restart_addr2",  64'(imem_addr), 64'h108);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
